// File: rtl/fb_pkg.sv
// Shared defaults and types for the framebuffer display viewport.
package fb_pkg;

  localparam int DEF_DISP_W = 800;
  localparam int DEF_DISP_H = 600;
  localparam int DEF_IMG_W  = 640;
  localparam int DEF_IMG_H  = 480;
  localparam int DEF_ADDR_W = 19;
  localparam int DEF_PIX_W  = 12;
  localparam int DEF_CRD_W  = 10;

  localparam logic [DEF_PIX_W-1:0] DEF_BORDER = 12'hFFF;

  typedef logic [DEF_PIX_W-1:0] pixel_t;

endpackage

// File: rtl/fb_viewport_sig_delay.sv
// Fixed-depth shift register that keeps side-band signals aligned with
// framebuffer read data.
module sig_delay #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else begin
      stage[0] <= d;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[DEPTH-1];

endmodule

// File: rtl/fb_viewport.sv
// Maps raster position to framebuffer read address with optional 2x zoom,
// inserts border colour outside the window and aligns syncs with read data.
module fb_viewport
  import fb_pkg::*;
#(
  parameter int DISP_W = DEF_DISP_W,
  parameter int DISP_H = DEF_DISP_H,
  parameter int IMG_W  = DEF_IMG_W,
  parameter int IMG_H  = DEF_IMG_H,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int PIX_W  = DEF_PIX_W,
  parameter int CRD_W  = DEF_CRD_W,
  parameter int RD_LAT = 2,
  parameter logic [PIX_W-1:0] BORDER = DEF_BORDER
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [CRD_W-1:0]  row_in,
  input  logic [CRD_W-1:0]  col_in,
  input  logic              de_in,
  input  logic              hsync_in,
  input  logic              vsync_in,
  input  logic [CRD_W-1:0]  x_off,
  input  logic [CRD_W-1:0]  y_off,
  input  logic              zoom,
  output logic [ADDR_W-1:0] fb_addr,
  input  logic [PIX_W-1:0]  fb_data,
  output logic [PIX_W-1:0]  rgb,
  output logic              hsync,
  output logic              vsync,
  output logic              de,
  output logic              frame_start
);

  localparam int W2 = CRD_W + 2;

  logic              frame_go, locked, locked_eff;
  logic              z_sh, z_eff, first_line, first_eff;
  logic [CRD_W-1:0]  x_sh, y_sh, x_eff, y_eff;
  logic [W2-1:0]     row_w, col_w, x_w, y_w, win_w, win_h;
  logic              in_win, line_start, line_adv, line_phase, col_phase;
  logic [ADDR_W-1:0] line_base, col_cnt, base_cur, col_cur;
  logic              win_d;
  logic [4:0]        pipe_q;

  // The frame-start cycle itself already uses the incoming offsets.
  always_comb begin
    frame_go   = de_in && (row_in == '0) && (col_in == '0);
    x_eff      = frame_go ? x_off : x_sh;
    y_eff      = frame_go ? y_off : y_sh;
    z_eff      = frame_go ? zoom  : z_sh;
    locked_eff = frame_go || locked;
    first_eff  = frame_go || first_line;

    row_w = W2'(row_in);
    col_w = W2'(col_in);
    x_w   = W2'(x_eff);
    y_w   = W2'(y_eff);
    win_w = z_eff ? W2'(2 * IMG_W) : W2'(IMG_W);
    win_h = z_eff ? W2'(2 * IMG_H) : W2'(IMG_H);

    in_win = de_in && locked_eff &&
             (row_w >= y_w) && (row_w < y_w + win_h) &&
             (col_w >= x_w) && (col_w < x_w + win_w) &&
             (row_w < W2'(DISP_H)) && (col_w < W2'(DISP_W));

    line_start = in_win && (col_in == x_eff);
    line_adv   = !first_eff && (!z_eff || line_phase);

    base_cur = line_base;
    if (line_start)
      base_cur = first_eff ? '0 : (line_adv ? line_base + ADDR_W'(IMG_W) : line_base);

    if (line_start)                 col_cur = '0;
    else if (!z_eff || col_phase)   col_cur = col_cnt + ADDR_W'(1);
    else                            col_cur = col_cnt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_sh       <= '0;
      y_sh       <= '0;
      z_sh       <= 1'b0;
      locked     <= 1'b0;
      first_line <= 1'b0;
      line_base  <= '0;
      line_phase <= 1'b0;
      col_cnt    <= '0;
      col_phase  <= 1'b0;
      fb_addr    <= '0;
    end else begin
      if (frame_go) begin
        x_sh       <= x_off;
        y_sh       <= y_off;
        z_sh       <= zoom;
        locked     <= 1'b1;
        first_line <= 1'b1;
        line_base  <= '0;
      end
      // Line start wins over the frame-start clear when both hit together.
      if (line_start) begin
        line_base  <= base_cur;
        line_phase <= first_eff ? 1'b0 : (z_eff ? !line_phase : 1'b0);
        first_line <= 1'b0;
      end
      if (in_win) begin
        col_cnt   <= col_cur;
        col_phase <= line_start ? 1'b0 : !col_phase;
        fb_addr   <= base_cur + col_cur;
      end
    end
  end

  sig_delay #(
    .WIDTH (5),
    .DEPTH (1 + RD_LAT)
  ) u_align (
    .clk   (clk),
    .rst_n (rst_n),
    .d     ({in_win, de_in, hsync_in, vsync_in, frame_go}),
    .q     (pipe_q)
  );

  assign {win_d, de, hsync, vsync, frame_start} = pipe_q;

  always_comb begin
    if (win_d)   rgb = fb_data;
    else if (de) rgb = BORDER;
    else         rgb = '0;
  end

endmodule
